// File: rtl/scoreboard_alu.sv
// Checker for an ALU and branch comparator, with branch-prediction statistics.
// Every counter saturates. Messages and the end-of-run report are simulation-only.
module scoreboard_alu #(
    parameter bit STOP_ON_ERR = 1'b0,
    parameter bit VERBOSE     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] drv_operand_a,
    input  logic [31:0] drv_operand_b,
    input  logic [3:0]  drv_alu_op,
    input  logic [31:0] act_alu_res,
    input  logic [31:0] drv_rs1_data,
    input  logic [31:0] drv_rs2_data,
    input  logic        drv_br_un,
    input  logic        act_br_eq,
    input  logic        act_br_lt,
    input  logic        i_is_br,
    input  logic        i_is_correct,
    output logic [31:0] o_alu_chk_cnt,
    output logic [31:0] o_alu_err_cnt,
    output logic [31:0] o_bc_err_cnt,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_br_ok_cnt,
    output logic        o_err
);
    logic [31:0] w_alu_exp;
    logic        w_alu_vld;
    logic        w_alu_bad;
    logic        w_exp_eq;
    logic        w_exp_lt;
    logic        w_bc_bad;
    logic [4:0]  w_sh;

    assign w_sh = drv_operand_b[4:0];

    always_comb begin
        w_alu_exp = 32'd0;
        w_alu_vld = 1'b1;
        case (drv_alu_op)
            4'd0:    w_alu_exp = drv_operand_a + drv_operand_b;
            4'd1:    w_alu_exp = drv_operand_a - drv_operand_b;
            4'd2:    w_alu_exp = drv_operand_a << w_sh;
            4'd3:    w_alu_exp = {31'd0, $signed(drv_operand_a) < $signed(drv_operand_b)};
            4'd4:    w_alu_exp = {31'd0, drv_operand_a < drv_operand_b};
            4'd5:    w_alu_exp = drv_operand_a ^ drv_operand_b;
            4'd6:    w_alu_exp = drv_operand_a >> w_sh;
            4'd7:    w_alu_exp = $unsigned($signed(drv_operand_a) >>> w_sh);
            4'd8:    w_alu_exp = drv_operand_a | drv_operand_b;
            4'd9:    w_alu_exp = drv_operand_a & drv_operand_b;
            4'd10:   w_alu_exp = drv_operand_b;
            default: w_alu_vld = 1'b0;
        endcase
    end

    // Case inequality so that X/Z on the checked values always counts as wrong.
    assign w_alu_bad = w_alu_vld && (act_alu_res !== w_alu_exp);
    assign w_exp_eq  = (drv_rs1_data == drv_rs2_data);
    assign w_exp_lt  = drv_br_un ? (drv_rs1_data < drv_rs2_data)
                                 : ($signed(drv_rs1_data) < $signed(drv_rs2_data));
    assign w_bc_bad  = (act_br_eq !== w_exp_eq) || (act_br_lt !== w_exp_lt);

    function automatic logic [31:0] f_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_chk_cnt <= 32'd0;
            o_alu_err_cnt <= 32'd0;
            o_bc_err_cnt  <= 32'd0;
            o_br_cnt      <= 32'd0;
            o_br_ok_cnt   <= 32'd0;
            o_err         <= 1'b0;
        end else begin
            if (w_alu_vld)              o_alu_chk_cnt <= f_inc(o_alu_chk_cnt);
            if (w_alu_bad)              o_alu_err_cnt <= f_inc(o_alu_err_cnt);
            if (w_bc_bad)               o_bc_err_cnt  <= f_inc(o_bc_err_cnt);
            if (i_is_br)                o_br_cnt      <= f_inc(o_br_cnt);
            if (i_is_br && i_is_correct) o_br_ok_cnt  <= f_inc(o_br_ok_cnt);
            if (w_alu_bad || w_bc_bad)  o_err         <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (VERBOSE && w_alu_bad)
                $error("%0t alu mismatch op=%0d a=%h b=%h exp=%h act=%h", $time,
                       drv_alu_op, drv_operand_a, drv_operand_b, w_alu_exp, act_alu_res);
            if (VERBOSE && w_bc_bad)
                $error("%0t cmp mismatch rs1=%h rs2=%h un=%b exp eq/lt=%b%b act eq/lt=%b%b",
                       $time, drv_rs1_data, drv_rs2_data, drv_br_un, w_exp_eq, w_exp_lt,
                       act_br_eq, act_br_lt);
            if (STOP_ON_ERR && (w_alu_bad || w_bc_bad))
                $fatal(1, "%0t scoreboard stopping on first mismatch", $time);
        end
    end

    final begin
        $display("scoreboard_alu: alu checks=%0d alu errors=%0d", o_alu_chk_cnt, o_alu_err_cnt);
        $display("scoreboard_alu: comparator errors=%0d", o_bc_err_cnt);
        if (o_br_cnt == 32'd0)
            $display("scoreboard_alu: branches=0 correct=0 accuracy=N/A");
        else
            $display("scoreboard_alu: branches=%0d correct=%0d accuracy=%0.2f%%", o_br_cnt,
                     o_br_ok_cnt, 100.0 * real'(o_br_ok_cnt) / real'(o_br_cnt));
        $display("scoreboard_alu: %s", o_err ? "FAIL" : "PASS");
    end
`endif
endmodule

// File: tb/tb_scoreboard_alu.sv
// Bench for scoreboard_alu: directed table, randomized run against a reference model,
// then unchecked-opcode, mid-run reset and branch-statistics sequences.
module tb_scoreboard_alu;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] a, b, act, r1, r2;
    logic [3:0]  op;
    logic        un, eq, lt, is_br, is_ok;
    logic [31:0] o_alu_chk_cnt, o_alu_err_cnt, o_bc_err_cnt, o_br_cnt, o_br_ok_cnt;
    logic        o_err;

    int total = 0;
    int bad   = 0;
    // reference counters
    longint m_chk, m_aerr, m_berr, m_br, m_ok;
    bit     m_err;

    always #5 i_clk = ~i_clk;

    scoreboard_alu #(.STOP_ON_ERR(1'b0), .VERBOSE(1'b0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .drv_operand_a(a), .drv_operand_b(b), .drv_alu_op(op), .act_alu_res(act),
        .drv_rs1_data(r1), .drv_rs2_data(r2), .drv_br_un(un),
        .act_br_eq(eq), .act_br_lt(lt),
        .i_is_br(is_br), .i_is_correct(is_ok),
        .o_alu_chk_cnt(o_alu_chk_cnt), .o_alu_err_cnt(o_alu_err_cnt),
        .o_bc_err_cnt(o_bc_err_cnt), .o_br_cnt(o_br_cnt), .o_br_ok_cnt(o_br_ok_cnt),
        .o_err(o_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, act, r1, r2;
        logic        un, eq, lt;
        int          d_chk, d_aerr, d_berr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " alu_chk"}, o_alu_chk_cnt, 32'(m_chk));
        chk({tag, " alu_err"}, o_alu_err_cnt, 32'(m_aerr));
        chk({tag, " bc_err"},  o_bc_err_cnt,  32'(m_berr));
        chk({tag, " br"},      o_br_cnt,      32'(m_br));
        chk({tag, " br_ok"},   o_br_ok_cnt,   32'(m_ok));
        chk({tag, " err"},     {31'd0, o_err}, {31'd0, m_err});
    endtask

    task automatic neutral();
        op = 4'd11; a = 0; b = 0; act = 0;
        r1 = 0; r2 = 0; un = 0; eq = 1; lt = 0;
        is_br = 0; is_ok = 0;
    endtask

    task automatic clr_model();
        m_chk = 0; m_aerr = 0; m_berr = 0; m_br = 0; m_ok = 0; m_err = 0;
    endtask

    // Reference ALU written from the operation definitions.
    function automatic bit ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r);
        int s = int'(y[4:0]);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        r = 0;
        case (o)
            0: r = 32'(longint'(x) + longint'(y));
            1: r = 32'(longint'(x) - longint'(y));
            2: r = x << s;
            3: r = (sx < sy) ? 1 : 0;
            4: r = (longint'(x) < longint'(y)) ? 1 : 0;
            5: r = x ^ y;
            6: r = x >> s;
            7: r = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            8: r = x | y;
            9: r = x & y;
            10: r = y;
            default: return 0;
        endcase
        return 1;
    endfunction

    function automatic void ref_cmp(input logic [31:0] x, input logic [31:0] y, input logic u,
                                    output logic e, output logic l);
        e = (x == y);
        l = u ? (longint'(x) < longint'(y)) : (longint'($signed(x)) < longint'($signed(y)));
    endfunction

    // Update the model with the current inputs, then clock the DUT and settle.
    task automatic step();
        logic [31:0] r;
        logic        e, l;
        if (ref_alu(op, a, b, r)) begin
            m_chk++;
            if (act !== r) begin m_aerr++; m_err = 1; end
        end
        ref_cmp(r1, r2, un, e, l);
        if (eq !== e || lt !== l) begin m_berr++; m_err = 1; end
        if (is_br) begin m_br++; if (is_ok) m_ok++; end
        @(posedge i_clk); #1;
    endtask

    vec_t vt[10];

    initial begin
        logic [31:0] r;
        logic        e, l;
        longint      t_chk, t_aerr, t_berr;
        vt[0] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 1, 0, 1, 0, 0};
        vt[1] = '{4'd7, 32'h8000_0000, 32'h21, 32'hC000_0000, 0, 0, 0, 1, 0, 1, 0, 0};
        vt[2] = '{4'd7, 32'h8000_0000, 32'h21, 32'h4000_0000, 0, 0, 0, 1, 0, 1, 1, 0};
        vt[3] = '{4'd11, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 0, 0, 0};
        vt[4] = '{4'd11, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 0, 0, 1};
        vt[5] = '{4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 1, 0, 1, 0, 0};
        vt[6] = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 1, 0, 1, 1, 0};
        vt[7] = '{4'd2, 32'd1, 32'h3F, 32'h8000_0000, 0, 0, 0, 1, 0, 1, 0, 0};
        vt[8] = '{4'd10, 32'd7, 32'h1234, 32'h1234, 32'd5, 32'd5, 0, 0, 1, 1, 0, 1};
        vt[9] = '{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 1, 0, 0};

        neutral();
        i_rst_n = 0;
        clr_model();
        repeat (2) @(posedge i_clk);
        #1;
        chk_all("reset");
        i_rst_n = 1;

        // Directed table: expected counters accumulate from the recorded deltas.
        t_chk = 0; t_aerr = 0; t_berr = 0;
        foreach (vt[i]) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b; act = vt[i].act;
            r1 = vt[i].r1; r2 = vt[i].r2; un = vt[i].un; eq = vt[i].eq; lt = vt[i].lt;
            step();
            t_chk += vt[i].d_chk; t_aerr += vt[i].d_aerr; t_berr += vt[i].d_berr;
            chk($sformatf("vec%0d alu_chk", i), o_alu_chk_cnt, 32'(t_chk));
            chk($sformatf("vec%0d alu_err", i), o_alu_err_cnt, 32'(t_aerr));
            chk($sformatf("vec%0d bc_err", i),  o_bc_err_cnt,  32'(t_berr));
            chk($sformatf("vec%0d err", i), {31'd0, o_err}, {31'd0, (t_aerr + t_berr) != 0});
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if (ref_alu(op, a, b, r)) act = ($urandom_range(0, 4) == 0) ? r ^ (32'd1 << $urandom_range(0, 31)) : r;
            else act = $urandom;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            un = 1'($urandom);
            ref_cmp(r1, r2, un, e, l);
            eq = ($urandom_range(0, 7) == 0) ? ~e : e;
            lt = ($urandom_range(0, 7) == 0) ? ~l : l;
            is_br = 1'($urandom); is_ok = 1'($urandom);
            step();
            chk_all($sformatf("rand%0d", n));
        end

        // Unchecked opcode with an X result leaves everything alone.
        neutral();
        op = 4'd13; act = 'x;
        step();
        chk_all("op13");

        // Asynchronous mid-run reset clears outputs before any clock edge.
        neutral();
        i_rst_n = 0;
        #1;
        clr_model();
        chk_all("async_rst");
        @(negedge i_clk);
        i_rst_n = 1;
        #1;

        // Branch statistics: 10 branches, 7 correct, plus 5 non-branch cycles with correct=1.
        for (int n = 0; n < 15; n++) begin
            neutral();
            is_br = (n < 10);
            is_ok = (n < 7) || (n >= 10);
            step();
        end
        chk("br_cnt 10", o_br_cnt, 32'd10);
        chk("br_ok_cnt 7", o_br_ok_cnt, 32'd7);
        chk_all("branch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
